seq_stream_sched: RTL

- Bit-serial stream scheduler and programmable pattern-detect controller.
- Accepts parallel words over a valid/ready handshake and serializes each word MSB-first, one bit per clock.
- Runs every emitted bit through a programmable pattern matcher and counts detections.
- Raises a sticky interrupt when the detection count reaches a threshold; sits between a word-wide producer and the serial detector path.

---
 rtl/seq_stream_sched_if.sv | 33 +++
 rtl/seq_stream_sched.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seq_stream_sched_if.sv
// rtl/seq_stream_sched_if.sv - word-in / bit-out handshake and control bundle for seq_stream_sched
interface seq_stream_sched_if #(
    parameter int DATA_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
);
    logic               enable;
    logic               overlap;
    logic [PAT_MAX-1:0] pat;
    logic [3:0]         pat_len;
    logic [CNT_W-1:0]   thresh;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic               bit_out;
    logic               bit_valid;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               irq;
    logic               irq_clr;
    logic               count_clr;
    logic               busy;

    modport master (
        output enable, overlap, pat, pat_len, thresh, in_data, in_valid, irq_clr, count_clr,
        input  in_ready, bit_out, bit_valid, detected, match_count, irq, busy
    );

    modport slave (
        input  enable, overlap, pat, pat_len, thresh, in_data, in_valid, irq_clr, count_clr,
        output in_ready, bit_out, bit_valid, detected, match_count, irq, busy
    );
endinterface

// File: rtl/seq_stream_sched.sv
// rtl/seq_stream_sched.sv - word serializer with programmable serial pattern detector and threshold irq
module seq_stream_sched #(
    parameter int DATA_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    seq_stream_sched_if.slave bus
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int LEN_W = $clog2(PAT_MAX + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  word_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_nxt;
    logic [PAT_MAX-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic               bit_out_q;
    logic               bit_valid_q;
    logic               busy_q;

    logic [PAT_MAX-1:0] hist_q;
    logic [LEN_W-1:0]   seen_q;
    logic               detected_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               irq_q;
    logic               irq_set;

    logic               last_bit;
    logic               accept;
    logic [LEN_W-1:0]   len_clamped;
    logic [PAT_MAX-1:0] hist_upd;
    logic [LEN_W-1:0]   seen_upd;
    logic [PAT_MAX-1:0] pat_mask;
    logic               match;

    // A new word may be taken in IDLE or on the final bit of the current word, which keeps
    // back-to-back words gapless. Reset gates in_ready so every output reads 0 while held.
    assign last_bit     = (state_q == S_SHIFT) && (idx_q == '0);
    assign bus.in_ready = reset & bus.enable & ((state_q == S_IDLE) | last_bit);
    assign accept       = bus.in_valid & bus.in_ready;
    assign idx_nxt      = idx_q - 1'b1;

    // Clamp the requested pattern length to what the history register can hold.
    always_comb begin
        len_clamped = LEN_W'(PAT_MAX);
        if (int'(bus.pat_len) <= PAT_MAX) begin
            len_clamped = LEN_W'(bus.pat_len);
        end
    end

    // Match against the history as it will look after absorbing the bit currently on bit_out.
    always_comb begin
        hist_upd = {hist_q[PAT_MAX-2:0], bit_out_q};
        seen_upd = (seen_q >= LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : seen_q + 1'b1;
        for (int i = 0; i < PAT_MAX; i++) begin
            pat_mask[i] = (i < int'(len_q));
        end
        match = bit_valid_q && (len_q != '0) && (seen_upd >= len_q) &&
                ((hist_upd & pat_mask) == (pat_q & pat_mask));
    end

    // Saturating detection count; a clear overrides an increment landing in the same cycle.
    always_comb begin
        count_d = count_q;
        if (bus.count_clr) begin
            count_d = '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
        irq_set = (bus.thresh != '0) && (count_d != count_q) && (count_d == bus.thresh);
    end

    // Serializer FSM: config is captured only at acceptance so mid-word changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            state_q     <= S_SHIFT;
            word_q      <= bus.in_data;
            idx_q       <= IDX_W'(DATA_W - 1);
            pat_q       <= bus.pat;
            len_q       <= len_clamped;
            ovl_q       <= bus.overlap;
            bit_out_q   <= bus.in_data[DATA_W-1];
            bit_valid_q <= 1'b1;
            busy_q      <= 1'b1;
        end else if ((state_q == S_SHIFT) && !last_bit) begin
            idx_q       <= idx_nxt;
            bit_out_q   <= word_q[idx_nxt];
        end else begin
            state_q     <= S_IDLE;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end
    end

    // Matcher history, detection pulse, counter and sticky irq (set beats a concurrent clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q     <= '0;
            seen_q     <= '0;
            detected_q <= 1'b0;
            count_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            detected_q <= 1'b0;
            if (bus.count_clr) begin
                hist_q <= '0;
                seen_q <= '0;
            end else if (bit_valid_q) begin
                hist_q     <= hist_upd;
                seen_q     <= (match && !ovl_q) ? '0 : seen_upd;
                detected_q <= match;
            end
            count_q <= count_d;
            irq_q   <= irq_set | (irq_q & ~bus.irq_clr);
        end
    end

    assign bus.bit_out     = bit_out_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.busy        = busy_q;
    assign bus.detected    = detected_q;
    assign bus.match_count = count_q;
    assign bus.irq         = irq_q;
endmodule
